// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between EX and the iterative 32-bit divider.
// Owns HI/LO, stalls the pipe during a divide, handles flush/div-by-zero/timeout.
module div_ctrl #(
   parameter int unsigned TIMEOUT   = 40,
   parameter bit          ZERO_SKIP = 1'b1
) (
   input  logic        div_clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_x,
   input  logic [31:0] req_y,
   output logic        req_ready,
   input  logic        cancel,
   input  logic [1:0]  hilo_we,
   input  logic [31:0] hilo_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall,
   output logic        done,
   output logic        timeout_err,
   output logic        dv_div,
   output logic        dv_signed,
   output logic [31:0] dv_x,
   output logic [31:0] dv_y,
   output logic        dv_rst,
   input  logic [31:0] dv_s,
   input  logic [31:0] dv_r,
   input  logic        dv_complete
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic [31:0]     x_q, x_d;
   logic [31:0]     y_q, y_d;
   logic            sgn_q, sgn_d;
   logic            done_q, done_d;
   logic            terr_q, terr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      x_d     = x_q;
      y_d     = y_q;
      sgn_d   = sgn_q;
      done_d  = 1'b0;
      terr_d  = terr_q;

      // MTHI/MTLO first so a divide result below overrides them
      if (hilo_we[1]) hi_d = hilo_wdata;
      if (hilo_we[0]) lo_d = hilo_wdata;

      unique case (state_q)
         S_IDLE: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else if (req_valid) begin
               if (ZERO_SKIP && (req_y == 32'd0)) begin
                  hi_d   = req_x;
                  lo_d   = 32'hFFFF_FFFF;
                  done_d = 1'b1;
               end else begin
                  x_d     = req_x;
                  y_d     = req_y;
                  sgn_d   = req_signed;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (dv_complete) begin
               lo_d    = dv_s;
               hi_d    = dv_r;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (cancel) begin
               state_d = S_FLUSH;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         sgn_q   <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sgn_q   <= sgn_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE) & ~rst;
   assign stall       = (state_q != S_IDLE);
   assign dv_div      = (state_q == S_RUN);
   assign dv_rst      = rst | (state_q == S_FLUSH);
   assign dv_signed   = sgn_q;
   assign dv_x        = x_q;
   assign dv_y        = y_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign done        = done_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a 33-cycle divider model.
// Expected HI/LO values are hand-computed constants.
module tb_div_ctrl;

   logic        div_clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_signed = 1'b0;
   logic [31:0] req_x = '0;
   logic [31:0] req_y = '0;
   logic        req_ready;
   logic        cancel = 1'b0;
   logic [1:0]  hilo_we = 2'b00;
   logic [31:0] hilo_wdata = '0;
   logic [31:0] hi, lo;
   logic        stall, done, timeout_err;
   logic        dv_div, dv_signed, dv_rst;
   logic [31:0] dv_x, dv_y, dv_s, dv_r;
   logic        dv_complete;

   logic        cplt_en = 1'b1;
   int          runcnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 div_clk = ~div_clk;

   div_ctrl #(.TIMEOUT(40), .ZERO_SKIP(1'b1)) dut (
      .div_clk     (div_clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_signed  (req_signed),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_ready   (req_ready),
      .cancel      (cancel),
      .hilo_we     (hilo_we),
      .hilo_wdata  (hilo_wdata),
      .hi          (hi),
      .lo          (lo),
      .stall       (stall),
      .done        (done),
      .timeout_err (timeout_err),
      .dv_div      (dv_div),
      .dv_signed   (dv_signed),
      .dv_x        (dv_x),
      .dv_y        (dv_y),
      .dv_rst      (dv_rst),
      .dv_s        (dv_s),
      .dv_r        (dv_r),
      .dv_complete (dv_complete)
   );

   // divider model: completes in its 33rd consecutive run cycle
   always @(posedge div_clk) begin
      if (dv_rst || !dv_div) runcnt <= 0;
      else                   runcnt <= runcnt + 1;
   end

   always_comb begin
      logic [31:0] ax, ay, q, r;
      logic        nx, ny;
      nx = dv_signed & dv_x[31];
      ny = dv_signed & dv_y[31];
      ax = nx ? -dv_x : dv_x;
      ay = ny ? -dv_y : dv_y;
      q  = 32'hFFFF_FFFF;
      r  = dv_x;
      if (ay != 0) begin
         q = ax / ay;
         r = ax % ay;
         if (nx ^ ny) q = -q;
         if (nx)      r = -r;
      end
      dv_s = q;
      dv_r = r;
      dv_complete = cplt_en & dv_div & (runcnt == 32);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic s, input logic [31:0] x,
                        input logic [31:0] y);
      @(negedge div_clk);
      req_valid  = 1'b1;
      req_signed = s;
      req_x      = x;
      req_y      = y;
      @(posedge div_clk);
      #1 req_valid = 1'b0;
   endtask

   // waits until stall drops; returns number of stalled cycles
   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge div_clk);
         if (!stall) break;
         n++;
      end
   endtask

   task automatic run_div(input string tag, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input int estall);
      int n;
      issue(s, x, y);
      wait_idle(n);
      chk({tag, "_stall"}, n, estall);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_lo"}, lo, elo);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
      @(negedge div_clk);
      chk({tag, "_done1"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int n, nrun, nfl;
      repeat (3) @(negedge div_clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_rdy", {31'd0, req_ready}, 32'd0);
      chk("rst_dvrst", {31'd0, dv_rst}, 32'd1);
      chk("rst_misc", {27'd0, stall, done, timeout_err, dv_div, dv_signed}, 32'd0);
      chk("rst_dvx", dv_x, 32'd0);
      rst = 1'b0;
      @(negedge div_clk);
      chk("rdy_after_rst", {31'd0, req_ready}, 32'd1);

      // DIVU 100/7 with operand and handshake probes in first RUN cycle
      issue(1'b0, 32'd100, 32'd7);
      @(negedge div_clk);
      chk("run_flags", {29'd0, stall, dv_div, req_ready}, 32'b110);
      chk("run_dvx", dv_x, 32'd100);
      chk("run_dvy", dv_y, 32'd7);
      wait_idle(n);
      chk("divu_stall", n, 32);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("divu_done", {31'd0, done}, 32'd1);
      @(negedge div_clk);
      chk("divu_done1", {31'd0, done}, 32'd0);

      run_div("div_neg", 1'b1, 32'hFFFF_FF9C, 32'd7,
              32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 32'd0, 33);
      run_div("divz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
      chk("divz_dvdiv", {31'd0, dv_div}, 32'd0);

      // cancel beats req_valid in IDLE
      @(negedge div_clk);
      cancel = 1'b1;
      req_valid = 1'b1;
      req_x = 32'd77;
      req_y = 32'd3;
      @(posedge div_clk);
      #1 cancel = 1'b0;
      req_valid = 1'b0;
      @(negedge div_clk);
      chk("idle_cancel", {30'd0, stall, req_ready}, 32'b01);

      // cancel in RUN cycle 10
      issue(1'b0, 32'd1000, 32'd3);
      repeat (9) @(negedge div_clk);
      @(negedge div_clk);
      cancel = 1'b1;
      @(posedge div_clk);
      #1 cancel = 1'b0;
      @(negedge div_clk);
      chk("flush_sig", {28'd0, dv_rst, dv_div, stall, req_ready}, 32'b1010);
      @(negedge div_clk);
      chk("flush_idle", {29'd0, stall, req_ready, done}, 32'b010);
      chk("flush_hi", hi, 32'd5);
      chk("flush_lo", lo, 32'hFFFF_FFFF);
      run_div("div93", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // MTHI in IDLE
      @(negedge div_clk);
      hilo_we = 2'b10;
      hilo_wdata = 32'hABCD;
      @(posedge div_clk);
      #1 hilo_we = 2'b00;
      @(negedge div_clk);
      chk("mthi", hi, 32'hABCD);
      chk("mthi_lo", lo, 32'd3);

      // MTLO in RUN cycle 5, then overwritten at done
      issue(1'b0, 32'd50, 32'd6);
      repeat (4) @(negedge div_clk);
      @(negedge div_clk);
      hilo_we = 2'b01;
      hilo_wdata = 32'h1234;
      @(posedge div_clk);
      #1 hilo_we = 2'b00;
      @(negedge div_clk);
      chk("mtlo_run", lo, 32'h1234);
      chk("mtlo_stall", {31'd0, stall}, 32'd1);
      wait_idle(n);
      chk("mtlo_lo", lo, 32'd8);
      chk("mtlo_hi", hi, 32'd2);

      // timeout with divider never completing
      cplt_en = 1'b0;
      issue(1'b0, 32'd7, 32'd1);
      nrun = 0;
      nfl = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge div_clk);
         if (!stall) break;
         if (dv_div) nrun++;
         if (dv_rst) nfl++;
      end
      chk("to_run", nrun, 40);
      chk("to_flush", nfl, 1);
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      chk("to_lo", lo, 32'd8);
      chk("to_hi", hi, 32'd2);
      chk("to_done", {31'd0, done}, 32'd0);
      @(negedge div_clk);
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);
      rst = 1'b1;
      @(negedge div_clk);
      rst = 1'b0;
      @(negedge div_clk);
      chk("to_clr", {31'd0, timeout_err}, 32'd0);
      chk("to_rst_lo", lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
